// File: rtl/keyboard_move_decoder.sv
//=============================================================================
// Module   : keyboard_move_decoder
// Brief    : Turns a PS/2 set-2 scan-code byte stream into held direction
//            levels (arrow keys, E0-extended) and a fire-held level plus a
//            one-cycle shoot pulse (space bar, non-extended).
// Options  : FIRE_AUTOREPEAT_EN - when defined, holding fire re-triggers
//            shoot every FIRE_REPEAT_FRAMES startOfFrame pulses.
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

module keyboard_move_decoder #(
   parameter logic [7:0] KEY_LEFT           = 8'h6B,
   parameter logic [7:0] KEY_RIGHT          = 8'h74,
   parameter logic [7:0] KEY_UP             = 8'h75,
   parameter logic [7:0] KEY_DOWN           = 8'h72,
   parameter logic [7:0] KEY_FIRE           = 8'h29,
   parameter int         TIMEOUT_CYCLES     = 2_500_000,
   parameter int         FIRE_REPEAT_FRAMES = 8
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       code_valid,
   input  logic [7:0] scan_code,
   input  logic       startOfFrame,
   output logic       move_left,
   output logic       move_right,
   output logic       move_up,
   output logic       move_down,
   output logic       fire_held,
   output logic       shoot
);

   localparam logic [7:0] C_CODE_EXT = 8'hE0;
   localparam logic [7:0] C_CODE_BRK = 8'hF0;

   localparam int              C_TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXT     = 2'd1,
      S_BRK     = 2'd2,
      S_EXT_BRK = 2'd3
   } state_t;

   state_t              r_state;
   logic [C_TO_W-1:0]   r_to_cnt;

   // Fire press from released state and fire release; these drive shoot and
   // the optional repeat counter.
   logic w_fire_make;
   logic w_fire_break;

   assign w_fire_make  = code_valid && (r_state == S_IDLE) &&
                         (scan_code == KEY_FIRE) && !fire_held;
   assign w_fire_break = code_valid && (r_state == S_BRK) &&
                         (scan_code == KEY_FIRE);

   // Prefix tracking FSM, prefix timeout and held-key flags.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state    <= S_IDLE;
         r_to_cnt   <= '0;
         move_left  <= 1'b0;
         move_right <= 1'b0;
         move_up    <= 1'b0;
         move_down  <= 1'b0;
         fire_held  <= 1'b0;
      end else if (code_valid) begin
         // Every received byte restarts the prefix timeout.
         r_to_cnt <= '0;
         case (r_state)
            S_IDLE: begin
               if (scan_code == C_CODE_EXT) begin
                  r_state <= S_EXT;
               end else if (scan_code == C_CODE_BRK) begin
                  r_state <= S_BRK;
               end else if (scan_code == KEY_FIRE) begin
                  fire_held <= 1'b1;
               end
            end
            S_EXT: begin
               if (scan_code == C_CODE_BRK) begin
                  r_state <= S_EXT_BRK;
               end else if (scan_code == C_CODE_EXT) begin
                  r_state <= S_EXT;
               end else begin
                  r_state <= S_IDLE;
                  if (scan_code == KEY_LEFT)  move_left  <= 1'b1;
                  if (scan_code == KEY_RIGHT) move_right <= 1'b1;
                  if (scan_code == KEY_UP)    move_up    <= 1'b1;
                  if (scan_code == KEY_DOWN)  move_down  <= 1'b1;
               end
            end
            S_BRK: begin
               r_state <= S_IDLE;
               if (scan_code == KEY_FIRE) fire_held <= 1'b0;
            end
            S_EXT_BRK: begin
               r_state <= S_IDLE;
               if (scan_code == KEY_LEFT)  move_left  <= 1'b0;
               if (scan_code == KEY_RIGHT) move_right <= 1'b0;
               if (scan_code == KEY_UP)    move_up    <= 1'b0;
               if (scan_code == KEY_DOWN)  move_down  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end else if (r_state != S_IDLE) begin
         // A lost follow-up byte must not leave the decoder stuck in a prefix.
         if (r_to_cnt == C_TO_LAST) begin
            r_state  <= S_IDLE;
            r_to_cnt <= '0;
         end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end
      end else begin
         r_to_cnt <= '0;
      end
   end

`ifdef FIRE_AUTOREPEAT_EN
   localparam int                C_FR_W    = (FIRE_REPEAT_FRAMES > 2) ? $clog2(FIRE_REPEAT_FRAMES) : 1;
   localparam logic [C_FR_W-1:0] C_FR_LAST = C_FR_W'(FIRE_REPEAT_FRAMES - 1);

   logic [C_FR_W-1:0] r_frame_cnt;

   // Shoot on the fire make edge, then again every FIRE_REPEAT_FRAMES frames
   // while fire stays held; the make edge wins over a coincident repeat.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_frame_cnt <= '0;
         shoot       <= 1'b0;
      end else if (w_fire_make || w_fire_break) begin
         r_frame_cnt <= '0;
         shoot       <= w_fire_make;
      end else if (fire_held && startOfFrame) begin
         if (r_frame_cnt == C_FR_LAST) begin
            r_frame_cnt <= '0;
            shoot       <= 1'b1;
         end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            shoot       <= 1'b0;
         end
      end else begin
         shoot <= 1'b0;
      end
   end
`else
   // Frame pacing is only meaningful for auto-repeat.
   localparam int c_frames_unused = FIRE_REPEAT_FRAMES;
   logic          w_sof_unused;
   logic          w_brk_unused;
   assign w_sof_unused = startOfFrame;
   assign w_brk_unused = w_fire_break;

   // Shoot only on the fire make edge; typematic repeats do not re-fire.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         shoot <= 1'b0;
      end else begin
         shoot <= w_fire_make;
      end
   end
`endif

endmodule

`default_nettype wire

// File: doc/keyboard_move_decoder.md
Name: keyboard_move_decoder

Overview:
- Converts the PS/2 scan-code byte stream (set 2) into held-key direction levels move_left/move_right/move_up/move_down and a fire pulse for the player movement and shot logic.
- Sits between the PS/2 byte receiver and the player movement block.
- Tracks make/break (F0) and extended (E0) prefixes with a small FSM, a prefix timeout counter and per-key held flags.

Parameters:
- KEY_LEFT, 8'h6B, extended code for left arrow (E0-prefixed)
- KEY_RIGHT, 8'h74, extended code for right arrow (E0-prefixed)
- KEY_UP, 8'h75, extended code for up arrow (E0-prefixed)
- KEY_DOWN, 8'h72, extended code for down arrow (E0-prefixed)
- KEY_FIRE, 8'h29, non-extended code for fire (space)
- TIMEOUT_CYCLES, 2_500_000, clk cycles a prefix state may wait for its next byte
- FIRE_REPEAT_FRAMES, 8, frames between auto-repeat shots (optional feature only)

Ports:
- clk, input, 1, system clock
- resetN, input, 1, asynchronous active-low reset
- code_valid, input, 1, one-cycle strobe: scan_code holds a complete received byte
- scan_code, input, 8, received byte
- startOfFrame, input, 1, one-cycle pulse per video frame (used only by the optional feature)
- move_left, output, 1, left arrow held
- move_right, output, 1, right arrow held
- move_up, output, 1, up arrow held
- move_down, output, 1, down arrow held
- fire_held, output, 1, fire key held
- shoot, output, 1, one-cycle fire pulse

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0, repeat counter 0.
- Bytes are processed only on cycles with code_valid=1. All outputs are registered. Held flags and shoot update on the clock edge that samples the final byte of a sequence, so they are visible 1 cycle after that strobe.
- FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - KEY_FIRE -> set fire_held. If fire_held was 0, assert shoot for 1 cycle. Typematic repeats of the make code give no further shoot.
  - Any other byte, including E1, is ignored and the FSM stays in IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay in EXT.
  - Arrow code -> set the matching held flag, then IDLE.
  - Other byte -> IDLE, no change.
- BRK:
  - KEY_FIRE -> clear fire_held, then IDLE.
  - Other byte -> IDLE, no change.
- EXT_BRK:
  - Arrow code -> clear the matching flag, then IDLE.
  - Other byte -> IDLE, no change.
- A non-extended byte equal to an arrow value (e.g. 6B = keypad 4) never affects the arrow flags. An extended 29 never affects fire.
- Timeout:
  - The counter runs while the FSM is in EXT, BRK or EXT_BRK and clears on every code_valid and on IDLE.
  - On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE with no flag change.
- Opposite directions held together (left+right, up+down) are both output as 1; resolving them is left to the consumer.
- Setting an already-set flag or clearing an already-clear flag is a no-op.
- Asynchronous reset mid-sequence returns the FSM to IDLE and clears every flag immediately.

Optional Feature:
- FIRE_AUTOREPEAT_EN defined:
  - While fire_held=1, a frame counter increments on each startOfFrame.
  - When it reaches FIRE_REPEAT_FRAMES, shoot pulses for 1 cycle and the counter reloads to 0.
  - The counter clears on the fire make edge (which itself pulses shoot) and on fire release.
  - If the make-edge pulse and a repeat pulse coincide, shoot pulses once.
- FIRE_AUTOREPEAT_EN undefined:
  - shoot pulses only on the fire make edge.
  - startOfFrame is ignored and no counter is synthesized.

Test Plan:
- Reset, then bytes E0,6B -> move_left=1 one cycle after the 6B strobe. Then E0,F0,6B -> move_left=0. Other outputs stay 0 throughout.
- Bytes 29,29,29 (typematic) -> fire_held=1, exactly one shoot pulse. Then F0,29 -> fire_held=0, no shoot.
- Non-extended 6B, then extended 29 -> no output change, FSM back in IDLE.
- Byte E0, then no strobe for TIMEOUT_CYCLES cycles (parameter set to 16), then 6B -> FSM returns to IDLE at timeout, and the later 6B does not set move_left.
- Left and right arrows made together, then up made, then resetN pulsed low mid-sequence after E0 -> move_left=move_right=move_up=1 before reset, all outputs 0 immediately after reset.
- FIRE_AUTOREPEAT_EN defined, FIRE_REPEAT_FRAMES=4, fire held for 10 startOfFrame pulses -> shoot at the make edge plus after frames 4 and 8 (3 pulses total). None after the F0,29 release.
